pcihellocore_button_ctrl: RTL and testbench

Avalon-MM slave that owns the board push buttons. It synchronizes and debounces the raw active-low key pins, keeps a clean level register, and latches press events in a write-1-to-clear edge-capture register. It raises a maskable interrupt toward the PCIe core and counts presses for host diagnostics. It sits in the pcihellocore system between the key pins and the Avalon interconnect, in the slot a plain input PIO would otherwise occupy.

---
 rtl/pcihellocore_button_pkg.sv | 11 +
 rtl/pcihellocore_button_debounce.sv | 56 +++++
 rtl/pcihellocore_button_ctrl.sv | 89 ++++++++
 tb/tb_pcihellocore_button_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcihellocore_button_pkg.sv
// Shared constants for the pcihellocore push-button controller.
package pcihellocore_button_pkg;

   localparam logic [1:0] ADDR_STATE     = 2'd0;
   localparam logic [1:0] ADDR_IRQ_MASK  = 2'd1;
   localparam logic [1:0] ADDR_EDGE_CAP  = 2'd2;
   localparam logic [1:0] ADDR_PRESS_CNT = 2'd3;

   localparam int PRESS_CNT_W = 16;

endpackage

// File: rtl/pcihellocore_button_debounce.sv
// One button: 2-flop synchronizer, stability counter, debounced level and a
// single-cycle press pulse that is valid on the edge where the level rises.
module pcihellocore_button_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic buttonN_i,
   output logic stable_o,
   output logic press_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             syncMeta_q;
   logic             sync_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             press;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         syncMeta_q <= 1'b0;
         sync_q     <= 1'b0;
         stable_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         syncMeta_q <= ~buttonN_i;
         sync_q     <= syncMeta_q;
         stable_q   <= stable_d;
         count_q    <= count_d;
      end
   end

   // Any return of sync to the accepted level drops the count back to zero.
   always_comb begin
      count_d  = '0;
      stable_d = stable_q;
      press    = 1'b0;
      if (sync_q != stable_q) begin
         if (count_q == LAST_COUNT) begin
            stable_d = sync_q;
            press    = sync_q;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   assign stable_o = stable_q;
   assign press_o  = press;

endmodule

// File: rtl/pcihellocore_button_ctrl.sv
// Avalon-MM button slave: debounced state, maskable edge-capture interrupt
// and a host-visible press counter.
module pcihellocore_button_ctrl
   import pcihellocore_button_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] buttons_n,
   output logic             irq
);

   logic [WIDTH-1:0]       stableVec;
   logic [WIDTH-1:0]       pressVec;
   logic [WIDTH-1:0]       irqMask_q;
   logic [WIDTH-1:0]       irqMask_d;
   logic [WIDTH-1:0]       edgeCap_q;
   logic [WIDTH-1:0]       edgeCap_d;
   logic [WIDTH-1:0]       clearMask;
   logic [PRESS_CNT_W-1:0] pressCnt_q;
   logic [PRESS_CNT_W-1:0] pressCnt_d;
   logic [31:0]            readdata_q;
   logic [31:0]            readdata_d;
   logic                   wrEn;
   logic                   unusedWritedata;

   genvar i;
   for (i = 0; i < WIDTH; i++) begin : gen_bit
      pcihellocore_button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk_i    (clk),
         .rst_n_i  (reset_n),
         .buttonN_i(buttons_n[i]),
         .stable_o (stableVec[i]),
         .press_o  (pressVec[i])
      );
   end

   assign wrEn            = chipselect & ~write_n;
   assign unusedWritedata = ^writedata;

   // A press landing with a clear wins, and a counter clear landing with a press leaves 1.
   always_comb begin
      irqMask_d  = irqMask_q;
      clearMask  = '0;
      pressCnt_d = pressCnt_q;
      if (wrEn && address == ADDR_IRQ_MASK) irqMask_d = writedata[WIDTH-1:0];
      if (wrEn && address == ADDR_EDGE_CAP) clearMask = writedata[WIDTH-1:0];
      if (wrEn && address == ADDR_PRESS_CNT) pressCnt_d = '0;
      if (|pressVec) pressCnt_d = pressCnt_d + 1'b1;
      edgeCap_d = (edgeCap_q & ~clearMask) | pressVec;
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_STATE:     readdata_d = 32'(stableVec);
         ADDR_IRQ_MASK:  readdata_d = 32'(irqMask_q);
         ADDR_EDGE_CAP:  readdata_d = 32'(edgeCap_q);
         ADDR_PRESS_CNT: readdata_d = 32'(pressCnt_q);
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqMask_q  <= '0;
         edgeCap_q  <= '0;
         pressCnt_q <= '0;
         readdata_q <= '0;
      end else begin
         irqMask_q  <= irqMask_d;
         edgeCap_q  <= edgeCap_d;
         pressCnt_q <= pressCnt_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_pcihellocore_button_ctrl.sv
// Directed bench for pcihellocore_button_ctrl with WIDTH=4, DEBOUNCE_CYCLES=8,
// so a clean press reaches STATE/EDGE_CAP exactly 10 clock edges after it is driven.
module tb_pcihellocore_button_ctrl;

   localparam int WIDTH = 4;
   localparam int DB    = 8;

   localparam logic [1:0] A_STATE = 2'd0;
   localparam logic [1:0] A_MASK  = 2'd1;
   localparam logic [1:0] A_EDGE  = 2'd2;
   localparam logic [1:0] A_CNT   = 2'd3;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] buttons_n;
   logic             irq;

   int checkCount = 0;
   int passCount  = 0;

   pcihellocore_button_ctrl #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .buttons_n (buttons_n),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are observed on the falling edge.
   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
      address    = addr;
      writedata  = data;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
      address = addr;
      @(negedge clk);
      data = readdata;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset_n    = 1'b0;
      address    = A_STATE;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      buttons_n  = 4'hF;
      waitCycles(3);
      checkCount++;
      if (readdata !== 32'h0) $display("[TB] FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
      else passCount++;
      checkCount++;
      if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected %b", irq, 1'b0);
      else passCount++;
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         busRead(2'(a), rd);
         checkCount++;
         if (rd !== 32'h0) $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, rd, 32'h0);
         else passCount++;
      end
   endtask

   task automatic test_press_timing();
      logic [31:0] rd;
      address   = A_STATE;
      buttons_n = 4'b1110;
      waitCycles(DB + 2);
      checkCount++;
      if (readdata !== 32'h0) $display("[TB] FAIL press_not_early: got %h expected %h", readdata, 32'h0);
      else passCount++;
      waitCycles(1);
      checkCount++;
      if (readdata !== 32'h1) $display("[TB] FAIL press_state: got %h expected %h", readdata, 32'h1);
      else passCount++;
      busRead(A_EDGE, rd);
      checkCount++;
      if (rd !== 32'h1) $display("[TB] FAIL press_edge: got %h expected %h", rd, 32'h1);
      else passCount++;
      busRead(A_CNT, rd);
      checkCount++;
      if (rd !== 32'h1) $display("[TB] FAIL press_cnt: got %h expected %h", rd, 32'h1);
      else passCount++;
      checkCount++;
      if (irq !== 1'b0) $display("[TB] FAIL press_irq_masked: got %b expected %b", irq, 1'b0);
      else passCount++;
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      busWrite(A_MASK, 32'h1);
      checkCount++;
      if (irq !== 1'b1) $display("[TB] FAIL irq_after_mask: got %b expected %b", irq, 1'b1);
      else passCount++;
      busRead(A_MASK, rd);
      checkCount++;
      if (rd !== 32'h1) $display("[TB] FAIL mask_readback: got %h expected %h", rd, 32'h1);
      else passCount++;
      busWrite(A_EDGE, 32'h1);
      checkCount++;
      if (irq !== 1'b0) $display("[TB] FAIL irq_after_clear: got %b expected %b", irq, 1'b0);
      else passCount++;
      busRead(A_EDGE, rd);
      checkCount++;
      if (rd !== 32'h0) $display("[TB] FAIL edge_cleared: got %h expected %h", rd, 32'h0);
      else passCount++;
      buttons_n = 4'hF;
      waitCycles(DB + 4);
      busRead(A_STATE, rd);
      checkCount++;
      if (rd !== 32'h0) $display("[TB] FAIL release_state: got %h expected %h", rd, 32'h0);
      else passCount++;
      busRead(A_EDGE, rd);
      checkCount++;
      if (rd !== 32'h0) $display("[TB] FAIL release_no_edge: got %h expected %h", rd, 32'h0);
      else passCount++;
      // New press on bit 0 lands on the same edge as a W1C of bit 0.
      buttons_n = 4'b1110;
      waitCycles(DB + 1);
      address    = A_EDGE;
      writedata  = 32'h1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      checkCount++;
      if (irq !== 1'b1) $display("[TB] FAIL set_wins_irq: got %b expected %b", irq, 1'b1);
      else passCount++;
      busRead(A_EDGE, rd);
      checkCount++;
      if (rd !== 32'h1) $display("[TB] FAIL set_wins_edge: got %h expected %h", rd, 32'h1);
      else passCount++;
      busRead(A_CNT, rd);
      checkCount++;
      if (rd !== 32'h2) $display("[TB] FAIL second_press_cnt: got %h expected %h", rd, 32'h2);
      else passCount++;
   endtask

   task automatic test_glitch();
      logic [31:0] rd;
      for (int n = 0; n < 10; n++) begin
         buttons_n[2] = 1'b0;
         waitCycles(5);
         buttons_n[2] = 1'b1;
         waitCycles(5);
      end
      waitCycles(DB + 4);
      busRead(A_STATE, rd);
      checkCount++;
      if (rd !== 32'h1) $display("[TB] FAIL glitch_state: got %h expected %h", rd, 32'h1);
      else passCount++;
      busRead(A_EDGE, rd);
      checkCount++;
      if (rd !== 32'h1) $display("[TB] FAIL glitch_edge: got %h expected %h", rd, 32'h1);
      else passCount++;
      busRead(A_CNT, rd);
      checkCount++;
      if (rd !== 32'h2) $display("[TB] FAIL glitch_cnt: got %h expected %h", rd, 32'h2);
      else passCount++;
   endtask

   task automatic test_multi_press();
      logic [31:0] rd;
      busWrite(A_EDGE, 32'hF);
      busWrite(A_MASK, 32'hFFFF_FFF0);
      busRead(A_MASK, rd);
      checkCount++;
      if (rd !== 32'h0) $display("[TB] FAIL mask_width: got %h expected %h", rd, 32'h0);
      else passCount++;
      buttons_n = 4'hF;
      waitCycles(DB + 4);
      buttons_n = 4'b0101;
      waitCycles(DB + 4);
      busRead(A_STATE, rd);
      checkCount++;
      if (rd !== 32'hA) $display("[TB] FAIL multi_state: got %h expected %h", rd, 32'hA);
      else passCount++;
      busRead(A_EDGE, rd);
      checkCount++;
      if (rd !== 32'hA) $display("[TB] FAIL multi_edge: got %h expected %h", rd, 32'hA);
      else passCount++;
      busRead(A_CNT, rd);
      checkCount++;
      if (rd !== 32'h3) $display("[TB] FAIL multi_cnt: got %h expected %h", rd, 32'h3);
      else passCount++;
      checkCount++;
      if (irq !== 1'b0) $display("[TB] FAIL multi_irq_masked: got %b expected %b", irq, 1'b0);
      else passCount++;
      busWrite(A_MASK, 32'h8);
      checkCount++;
      if (irq !== 1'b1) $display("[TB] FAIL multi_irq_bit3: got %b expected %b", irq, 1'b1);
      else passCount++;
   endtask

   task automatic test_count_wrap();
      logic [31:0] rd;
      buttons_n = 4'hF;
      waitCycles(DB + 4);
      force dut.pressCnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.pressCnt_q;
      busRead(A_CNT, rd);
      checkCount++;
      if (rd !== 32'hFFFF) $display("[TB] FAIL cnt_preload: got %h expected %h", rd, 32'hFFFF);
      else passCount++;
      buttons_n = 4'b1110;
      waitCycles(DB + 4);
      busRead(A_CNT, rd);
      checkCount++;
      if (rd !== 32'h0) $display("[TB] FAIL cnt_wrap: got %h expected %h", rd, 32'h0);
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      buttons_n = 4'hF;
      waitCycles(DB + 4);
      buttons_n = 4'b1101;
      waitCycles(DB + 4);
      busRead(A_CNT, rd);
      checkCount++;
      if (rd !== 32'h1) $display("[TB] FAIL cnt_before_clear: got %h expected %h", rd, 32'h1);
      else passCount++;
      // Counter clear lands on the same edge as the bit 2 press.
      buttons_n = 4'b1001;
      waitCycles(DB + 1);
      address    = A_CNT;
      writedata  = 32'h0;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      busRead(A_CNT, rd);
      checkCount++;
      if (rd !== 32'h1) $display("[TB] FAIL cnt_clear_and_press: got %h expected %h", rd, 32'h1);
      else passCount++;
   endtask

   task automatic test_reset_mid_debounce();
      logic [31:0] rd;
      buttons_n = 4'hF;
      waitCycles(DB + 4);
      buttons_n = 4'b1110;
      waitCycles(4);
      reset_n = 1'b0;
      #1;
      checkCount++;
      if (readdata !== 32'h0) $display("[TB] FAIL midreset_readdata: got %h expected %h", readdata, 32'h0);
      else passCount++;
      checkCount++;
      if (irq !== 1'b0) $display("[TB] FAIL midreset_irq: got %b expected %b", irq, 1'b0);
      else passCount++;
      waitCycles(2);
      reset_n = 1'b1;
      for (int a = 1; a < 4; a++) begin
         busRead(2'(a), rd);
         checkCount++;
         if (rd !== 32'h0) $display("[TB] FAIL midreset_reg%0d: got %h expected %h", a, rd, 32'h0);
         else passCount++;
      end
      address = A_STATE;
      waitCycles(DB + 2 - 3);
      checkCount++;
      if (readdata !== 32'h0) $display("[TB] FAIL postreset_not_early: got %h expected %h", readdata, 32'h0);
      else passCount++;
      waitCycles(1);
      checkCount++;
      if (readdata !== 32'h1) $display("[TB] FAIL postreset_state: got %h expected %h", readdata, 32'h1);
      else passCount++;
   endtask

   initial begin
      test_reset();
      test_press_timing();
      test_irq();
      test_glitch();
      test_multi_press();
      test_count_wrap();
      test_back_to_back();
      test_reset_mid_debounce();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
